// File: rtl/rvm_mem_responder_pkg.sv
// Shared types and constants for the memory responder: FSM encoding,
// legal byte-enable patterns and the mem_w_en meaning.
package rvm_mem_responder_pkg;

  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_WAIT = 2'd1,
    RSP_RESP = 2'd2
  } rsp_state_e;

  // Byte, halfword and word lane patterns the core may present.
  localparam logic [3:0] BEN_B0 = 4'b0001;
  localparam logic [3:0] BEN_B1 = 4'b0010;
  localparam logic [3:0] BEN_B2 = 4'b0100;
  localparam logic [3:0] BEN_B3 = 4'b1000;
  localparam logic [3:0] BEN_H0 = 4'b0011;
  localparam logic [3:0] BEN_H1 = 4'b1100;
  localparam logic [3:0] BEN_W  = 4'b1111;

  localparam logic MEM_W_EN_READ  = 1'b0;
  localparam logic MEM_W_EN_WRITE = 1'b1;

  function automatic logic b_en_legal(input logic [3:0] b_en);
    case (b_en)
      BEN_B0, BEN_B1, BEN_B2, BEN_B3, BEN_H0, BEN_H1, BEN_W: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rvm_mem_responder_if.sv
// Core-to-memory request/response bus. The core is the master, the
// responder the slave.
interface rvm_mem_responder_if;

  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;
  logic        mem_c_en;
  logic        mem_w_en;
  logic [3:0]  mem_b_en;
  logic        mem_error;
  logic        mem_stall;

  modport master (
    output mem_addr, mem_wdata, mem_c_en, mem_w_en, mem_b_en,
    input  mem_rdata, mem_error, mem_stall
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_c_en, mem_w_en, mem_b_en,
    output mem_rdata, mem_error, mem_stall
  );

endinterface

// File: rtl/rvm_mem_responder_sram.sv
// Single-port word RAM with byte write enables and a registered read whose
// disabled lanes read as zero; the read register clears when idle.
module rvm_mem_responder_sram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: the array itself carries no reset; resetting a RAM would force it
  // into flops, so only the read register below is reset.
  always_ff @(posedge clk) begin
    if (req && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // The read register doubles as the responder's mem_rdata output, so it
  // returns to zero in every cycle that is not a read response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (req && !we) begin
      for (int i = 0; i < 4; i++) begin
        rdata[8*i +: 8] <= be[i] ? mem[idx][8*i +: 8] : 8'h00;
      end
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/rvm_mem_responder.sv
// Memory-side responder: accepts one request at a time, inserts a fixed
// number of stall cycles, checks the access and drives a one-cycle response.
module rvm_mem_responder
  import rvm_mem_responder_pkg::*;
#(
  parameter int          MEM_DEPTH    = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          STALL_CYCLES = 2
) (
  input logic              clk,
  input logic              reset,
  rvm_mem_responder_if.slave bus
);

  localparam int         AW         = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] STALL_INIT = 4'((STALL_CYCLES > 0) ? STALL_CYCLES - 1 : 0);

  rsp_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        stall_q, stall_d;
  logic        error_q, error_d;

  logic [31:0] addr_q, wdata_q;
  logic        w_en_q;
  logic [3:0]  b_en_q;

  logic        capture;
  logic        exec;
  logic        use_bus;

  logic [31:0] acc_addr, acc_wdata, acc_offset;
  logic        acc_w_en;
  logic [3:0]  acc_b_en;
  logic        acc_err;
  logic [AW-1:0] acc_idx;
  logic [31:0] sram_rdata;

  // NOTE: every always_comb output gets a default first so no path through
  // the case leaves a value unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_d = 1'b0;
    capture = 1'b0;
    exec    = 1'b0;
    use_bus = 1'b0;

    case (state_q)
      RSP_IDLE, RSP_RESP: begin
        if (bus.mem_c_en) begin
          capture = 1'b1;
          if (STALL_CYCLES > 0) begin
            state_d = RSP_WAIT;
            cnt_d   = STALL_INIT;
            stall_d = 1'b1;
          end else begin
            exec    = 1'b1;
            use_bus = 1'b1;
            state_d = RSP_RESP;
          end
        end else begin
          state_d = RSP_IDLE;
        end
      end
      RSP_WAIT: begin
        // Dropping the request while stalled abandons it without a write.
        if (!bus.mem_c_en) begin
          state_d = RSP_IDLE;
        end else if (cnt_q == 4'd0) begin
          exec    = 1'b1;
          state_d = RSP_RESP;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          stall_d = 1'b1;
        end
      end
      default: state_d = RSP_IDLE;
    endcase
  end

  // With zero stall cycles the access executes in its accept cycle, straight
  // from the bus; otherwise it runs from the captured copy.
  assign acc_addr  = use_bus ? bus.mem_addr  : addr_q;
  assign acc_wdata = use_bus ? bus.mem_wdata : wdata_q;
  assign acc_w_en  = use_bus ? bus.mem_w_en  : w_en_q;
  assign acc_b_en  = use_bus ? bus.mem_b_en  : b_en_q;

  assign acc_offset = acc_addr - BASE_ADDR;
  assign acc_idx    = AW'(acc_offset >> 2);
  assign acc_err    = (acc_addr[1:0] != 2'b00)
                   || (acc_addr < BASE_ADDR)
                   || ((acc_offset >> 2) >= 32'(MEM_DEPTH))
                   || !b_en_legal(acc_b_en);

  assign error_d = exec && acc_err;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RSP_IDLE;
      cnt_q   <= 4'd0;
      stall_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      w_en_q  <= MEM_W_EN_READ;
      b_en_q  <= '0;
    end else if (capture) begin
      addr_q  <= bus.mem_addr;
      wdata_q <= bus.mem_wdata;
      w_en_q  <= bus.mem_w_en;
      b_en_q  <= bus.mem_b_en;
    end
  end

  rvm_mem_responder_sram #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .reset (reset),
    .req   (exec && !acc_err),
    .we    (acc_w_en == MEM_W_EN_WRITE),
    .be    (acc_b_en),
    .idx   (acc_idx),
    .wdata (acc_wdata),
    .rdata (sram_rdata)
  );

  assign bus.mem_rdata = sram_rdata;
  assign bus.mem_error = error_q;
  assign bus.mem_stall = stall_q;

endmodule
